// File: rtl/sched_pkg.sv
// Shared definitions for the scheduler controller: config opcodes, cause codes,
// FSM states and the priority pick used when entering a request.
package sched_pkg;

  localparam int VEC_W = 16;

  typedef enum logic [3:0] {
    OP_VEC_SYS = 4'b0001,
    OP_VEC_TMR = 4'b0010,
    OP_VEC_DMA = 4'b0011,
    OP_START   = 4'b0100,
    OP_RST_TMR = 4'b0101
  } sched_op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_SYS  = 2'b01,
    CAUSE_DMA  = 2'b10,
    CAUSE_TMR  = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_REQ,
    ST_SERVICE
  } state_e;

  // Pending bits are indexed by cause code: [1] syscall, [2] DMA, [3] timer.
  function automatic cause_e pick_cause(input logic [3:1] pend);
    if (pend[1]) return CAUSE_SYS;
    if (pend[2]) return CAUSE_DMA;
    if (pend[3]) return CAUSE_TMR;
    return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/sched_if.sv
// Config stream, event inputs and interrupt handshake between the decoder/core
// (master) and the scheduler controller (slave).
interface sched_if;
  import sched_pkg::*;

  logic             SCHED_conf;
  logic [3:0]       SCHED_OP;
  logic [VEC_W-1:0] SCHED_value;
  logic [VEC_W-1:0] PC_pos;
  logic             syscall_req;
  logic             dma_done;
  logic             int_ack;
  logic             int_ret;
  logic             int_req;
  logic [VEC_W-1:0] int_vector;
  logic [1:0]       int_cause;
  logic [VEC_W-1:0] saved_PC;
  logic             sched_running;

  modport master (
    output SCHED_conf, SCHED_OP, SCHED_value, PC_pos,
    output syscall_req, dma_done, int_ack, int_ret,
    input  int_req, int_vector, int_cause, saved_PC, sched_running
  );

  modport slave (
    input  SCHED_conf, SCHED_OP, SCHED_value, PC_pos,
    input  syscall_req, dma_done, int_ack, int_ret,
    output int_req, int_vector, int_cause, saved_PC, sched_running
  );

endinterface

// File: rtl/sched_timer.sv
// Quantum register and down-counter; pulses expire on the counter==1 RUN edge
// unless a config load on the same edge takes precedence.
module sched_timer #(
  parameter int QUANTUM_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [QUANTUM_W-1:0] load_val,
  input  logic                 run,
  input  logic                 reload,
  output logic                 expire
);

  logic [QUANTUM_W-1:0] quantum_q;
  logic [QUANTUM_W-1:0] counter_q;
  logic                 enabled;

  assign enabled = (quantum_q != '0);
  assign expire  = run && enabled && !load && (counter_q == QUANTUM_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      quantum_q <= '0;
      counter_q <= '0;
    end else if (load) begin
      quantum_q <= load_val;
      counter_q <= load_val;
    end else if (reload) begin
      counter_q <= quantum_q;
    end else if (run && enabled) begin
      // Reloading at 1 keeps the count from ever reaching zero.
      counter_q <= (counter_q == QUANTUM_W'(1)) ? quantum_q : counter_q - QUANTUM_W'(1);
    end
  end

endmodule

// File: rtl/sched_controller.sv
// Scheduler controller: holds handler vectors, latches pending events and runs
// the request/ack/return handshake with the fetch stage.
module sched_controller
  import sched_pkg::*;
#(
  parameter int QUANTUM_W = 16
) (
  input  logic     clk,
  input  logic     reset,
  sched_if.slave   bus
);

  state_e           state_q, state_n;
  logic [VEC_W-1:0] vec_sys_q, vec_tmr_q, vec_dma_q;
  logic [3:1]       pend_q, pend_n, pend_eff;
  cause_e           cause_q, sel_cause;
  logic [VEC_W-1:0] vector_q, sel_vec, saved_pc_q;
  logic             cfg_start, cfg_tmr_load, tmr_expire, enter_req;

  assign cfg_start    = bus.SCHED_conf && (bus.SCHED_OP == OP_START);
  assign cfg_tmr_load = cfg_start || (bus.SCHED_conf && (bus.SCHED_OP == OP_RST_TMR));

  sched_timer #(.QUANTUM_W(QUANTUM_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (cfg_tmr_load),
    .load_val (QUANTUM_W'(bus.SCHED_value)),
    .run      (state_q == ST_RUN),
    .reload   ((state_q == ST_SERVICE) && bus.int_ret),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      vec_sys_q <= '0;
      vec_tmr_q <= '0;
      vec_dma_q <= '0;
    end else if (bus.SCHED_conf) begin
      case (bus.SCHED_OP)
        OP_VEC_SYS: vec_sys_q <= bus.SCHED_value;
        OP_VEC_TMR: vec_tmr_q <= bus.SCHED_value;
        OP_VEC_DMA: vec_dma_q <= bus.SCHED_value;
        default: ;
      endcase
    end
  end

  // A zero vector masks its source, including a bit latched before the mask.
  assign pend_eff  = pend_q & {(vec_tmr_q != '0), (vec_dma_q != '0), (vec_sys_q != '0)};
  assign sel_cause = pick_cause(pend_eff);

  always_comb begin
    sel_vec = '0;
    case (sel_cause)
      CAUSE_SYS: sel_vec = vec_sys_q;
      CAUSE_DMA: sel_vec = vec_dma_q;
      CAUSE_TMR: sel_vec = vec_tmr_q;
      default:   sel_vec = '0;
    endcase
  end

  always_comb begin
    pend_n = pend_q;
    if ((state_q == ST_REQ) && bus.int_ack) begin
      case (cause_q)
        CAUSE_SYS: pend_n[1] = 1'b0;
        CAUSE_DMA: pend_n[2] = 1'b0;
        CAUSE_TMR: pend_n[3] = 1'b0;
        default: ;
      endcase
    end
    if (state_q != ST_IDLE) begin
      if (bus.syscall_req) pend_n[1] = 1'b1;
      if (bus.dma_done)    pend_n[2] = 1'b1;
      if (tmr_expire)      pend_n[3] = 1'b1;
    end
    if (vec_sys_q == '0) pend_n[1] = 1'b0;
    if (vec_dma_q == '0) pend_n[2] = 1'b0;
    if (vec_tmr_q == '0) pend_n[3] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_n;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  // FSM: next state
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:    if (cfg_start)     state_n = ST_RUN;
      ST_RUN:     if (|pend_eff)     state_n = ST_REQ;
      ST_REQ:     if (bus.int_ack)   state_n = ST_SERVICE;
      ST_SERVICE: if (bus.int_ret)   state_n = ST_RUN;
      default:                       state_n = ST_IDLE;
    endcase
  end

  assign enter_req = (state_q == ST_RUN) && (state_n == ST_REQ);

  // Request payload is captured once on entry and frozen through REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      cause_q    <= CAUSE_NONE;
      vector_q   <= '0;
      saved_pc_q <= '0;
    end else if (enter_req) begin
      cause_q    <= sel_cause;
      vector_q   <= sel_vec;
      saved_pc_q <= bus.PC_pos;
    end
  end

  // FSM: outputs
  always_comb begin
    bus.int_req       = (state_q == ST_REQ);
    bus.sched_running = (state_q != ST_IDLE);
    bus.int_cause     = cause_q;
    bus.int_vector    = vector_q;
    bus.saved_PC      = saved_pc_q;
  end

endmodule

// File: tb/tb_sched_controller.sv
// Directed bench for sched_controller with a request scoreboard.
module tb_sched_controller;
  import sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sched_if bus();

  sched_controller #(.QUANTUM_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  cause;
    logic [15:0] vector;
  } req_t;

  req_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] pc_prev;

  task automatic tick();
    @(posedge clk);
    pc_prev = bus.PC_pos;
    #1;
    bus.PC_pos = bus.PC_pos + 16'd2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_int_req"}, 32'(bus.int_req), 0);
    check({tag, "_running"}, 32'(bus.sched_running), 0);
    check({tag, "_vector"},  32'(bus.int_vector), 0);
    check({tag, "_cause"},   32'(bus.int_cause), 0);
    check({tag, "_saved_pc"}, 32'(bus.saved_PC), 0);
  endtask

  task automatic cfg(input logic [3:0] op, input logic [15:0] val);
    bus.SCHED_conf  = 1'b1;
    bus.SCHED_OP    = op;
    bus.SCHED_value = val;
    tick();
    bus.SCHED_conf  = 1'b0;
    bus.SCHED_OP    = 4'h0;
    bus.SCHED_value = 16'h0;
  endtask

  task automatic ack();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic ret();
    bus.int_ret = 1'b1;
    tick();
    bus.int_ret = 1'b0;
  endtask

  task automatic pulse(input logic sys, input logic dma);
    bus.syscall_req = sys;
    bus.dma_done    = dma;
    tick();
    bus.syscall_req = 1'b0;
    bus.dma_done    = 1'b0;
  endtask

  task automatic expect_req(input logic [1:0] cause, input logic [15:0] vector);
    req_t e;
    e.cause  = cause;
    e.vector = vector;
    sb.push_back(e);
  endtask

  task automatic no_req(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, 32'(bus.int_req), 0);
    end
  endtask

  // Waits (bounded) for int_req, checks latency and the oldest expected request.
  task automatic wait_req(input string tag, input int exp_lat);
    int   lat;
    req_t e;
    lat = 0;
    while (bus.int_req !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_cause"},    32'(bus.int_cause),  32'(e.cause));
      check({tag, "_vector"},   32'(bus.int_vector), 32'(e.vector));
      check({tag, "_saved_pc"}, 32'(bus.saved_PC),   32'(pc_prev));
    end
  endtask

  initial begin
    bus.SCHED_conf  = 1'b0;
    bus.SCHED_OP    = 4'h0;
    bus.SCHED_value = 16'h0;
    bus.PC_pos      = 16'h1000;
    bus.syscall_req = 1'b0;
    bus.dma_done    = 1'b0;
    bus.int_ack     = 1'b0;
    bus.int_ret     = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    check_idle_outputs("reset");
    reset = 1'b0;

    // Timer quantum 5: request 6 cycles after start, again 6 after return.
    cfg(OP_VEC_TMR, 16'h0100);
    check("idle_not_running", 32'(bus.sched_running), 0);
    cfg(OP_START, 16'd5);
    check("start_running", 32'(bus.sched_running), 1);
    expect_req(2'b11, 16'h0100);
    wait_req("tmr1", 6);
    tick();
    check("req_held", 32'(bus.int_req), 1);
    ack();
    check("ack_drop", 32'(bus.int_req), 0);
    no_req("svc_hold", 3);
    ret();
    expect_req(2'b11, 16'h0100);
    wait_req("tmr2", 6);
    ack();
    cfg(OP_RST_TMR, 16'd0);
    ret();

    // Same-edge syscall and DMA: syscall first, DMA after return.
    cfg(OP_VEC_SYS, 16'h0200);
    cfg(OP_VEC_DMA, 16'h0300);
    pulse(1'b1, 1'b1);
    expect_req(2'b01, 16'h0200);
    expect_req(2'b10, 16'h0300);
    wait_req("pair_sys", 1);
    ack();
    tick();
    ret();
    wait_req("pair_dma", 1);
    ack();
    ret();

    // Ack with a new syscall on the same edge, held until return.
    pulse(1'b0, 1'b1);
    expect_req(2'b10, 16'h0300);
    wait_req("dma3", 1);
    bus.int_ack     = 1'b1;
    bus.syscall_req = 1'b1;
    tick();
    bus.int_ack     = 1'b0;
    bus.syscall_req = 1'b0;
    check("svc_running", 32'(bus.sched_running), 1);
    check("svc_no_req", 32'(bus.int_req), 0);
    no_req("svc_sys_wait", 3);
    ret();
    expect_req(2'b01, 16'h0200);
    wait_req("sys3", 1);
    ack();
    ret();

    // Masked DMA source, then unmasked.
    cfg(OP_VEC_DMA, 16'h0000);
    pulse(1'b0, 1'b1);
    no_req("dma_masked", 4);
    cfg(OP_VEC_DMA, 16'h0400);
    pulse(1'b0, 1'b1);
    expect_req(2'b10, 16'h0400);
    wait_req("dma4", 1);
    ack();
    ret();

    // Reset-timer write on the counter==1 edge of quantum 8 wins.
    cfg(OP_RST_TMR, 16'd8);
    no_req("q8_count", 7);
    cfg(OP_RST_TMR, 16'd3);
    expect_req(2'b11, 16'h0100);
    wait_req("tmr5", 4);

    // Reset while requesting.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("mid_req_reset");
    ack();
    check("stray_ack_req", 32'(bus.int_req), 0);
    check("stray_ack_running", 32'(bus.sched_running), 0);
    cfg(OP_START, 16'd3);
    pulse(1'b1, 1'b1);
    no_req("vectors_cleared", 6);
    check("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sched_controller.md
# sched_controller

Sequential scheduler that consumes the configuration stream from the scheduler decoder (SCHED_conf / SCHED_OP / SCHED_value) and raises prioritised interrupt requests to the core for syscalls, DMA completion and timer-quantum expiry. It holds the per-source handler vectors and the timer quantum, counts the quantum down, latches pending events, and runs a request/acknowledge/return handshake with the fetch stage, which redirects PC to the supplied vector.

## Interface
- QUANTUM_W, 16: width of the quantum register and the down-counter.

- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- SCHED_conf  in  1  config strobe, valid for one cycle.
- SCHED_OP  in  4  config opcode: 0001 syscall vector, 0010 timer vector, 0011 DMA vector, 0100 start, 0101 reset timer.
- SCHED_value  in  16  config operand.
- PC_pos  in  16  current PC, captured on interrupt entry.
- syscall_req  in  1  single-cycle syscall event from execute.
- dma_done  in  1  single-cycle DMA completion event.
- int_ack  in  1  core accepted int_req this cycle.
- int_ret  in  1  handler return executed.
- int_req  out  1  interrupt request to core.
- int_vector  out  16  handler address, stable while int_req is high.
- int_cause  out  2  01 syscall, 10 DMA, 11 timer, 00 none.
- saved_PC  out  16  PC_pos captured on the REQ entry edge.
- sched_running  out  1  high in RUN, REQ and SERVICE.

## Operation
- Registers: vec_sys, vec_tmr, vec_dma (16 b), quantum, counter (QUANTUM_W), pend[3:1] (syscall, DMA, timer).
- Config, applied on the edge where SCHED_conf=1, in any state:
  - 0001/0010/0011 load the corresponding vector.
  - 0100 (start) loads quantum and counter from SCHED_value and goes IDLE→RUN; in other states it reloads only.
  - 0101 (reset timer) loads quantum and counter from SCHED_value.
  - Other opcodes are ignored.
- Vector value 0 masks its source: the event is not latched, and an existing pend bit is cleared on that edge.
- Quantum 0 disables the timer; the counter holds.
- FSM:
  - IDLE: timer frozen. Events are not latched.
  - RUN: counter decrements each cycle. When counter==1, it reloads quantum and sets pend[timer]. If any pend bit is set, go to REQ, latching the highest-priority source (syscall > DMA > timer) into int_cause/int_vector and PC_pos into saved_PC.
  - REQ: int_req=1. Outputs are frozen even if a higher-priority event arrives. On int_ack, clear that pend bit and go to SERVICE.
  - SERVICE: counter frozen. Events are still latched. On int_ret, reload counter from quantum and go to RUN.
- Events are latched in RUN, REQ and SERVICE. A repeated event of an already-pending source merges into the single pend bit.
- Priority of same-edge arrivals is resolved at selection time.

## Timing
- Reset:
  - All outputs are 0, state is IDLE.
  - Vectors, quantum, counter and pend are all 0.
  - Reset mid-handshake drops int_req on the next edge with no ack required.
- Event latency: event at edge N sets pend at N; REQ is entered at N+1, so int_req is high in the cycle after N+1.
- Timer: after start/reload with quantum Q, pend[timer] is set on the Q-th RUN edge.
- int_ack with int_req low is ignored. int_ret outside SERVICE is ignored.
- int_ack and a new event on the same edge: the new event is latched and the acked bit is cleared.
- A config write on the same edge as counter==1 wins: it reloads and no pend is set.
- Counter and quantum are unsigned. Decrement never wraps below 1 because reload happens at 1.

## Structure
- Shared package (sched_pkg): SCHED_OP encodings, cause codes, FSM state enum, vector width 16.
- One natural sub-module, sched_timer, containing quantum, counter, reload/freeze logic and the expiry pulse.
- Priority select and FSM live in the top.

## Test plan
- Start with value 5, vec_tmr=0x0100: int_req rises with int_cause=11 and int_vector=0x0100 exactly 6 cycles after start. Ack then ret: the next expiry follows 5 RUN cycles later.
- vec_sys=0x0200, vec_dma=0x0300; syscall_req and dma_done on the same edge: first request is cause 01 / 0x0200. After ack and ret, the second request is cause 10 / 0x0300.
- syscall_req while in SERVICE: no int_req until int_ret, then REQ one edge later. saved_PC equals PC_pos at REQ entry.
- vec_dma=0 with a dma_done pulse: no request. Then set vec_dma=0x0400 and pulse again: request with 0x0400.
- Reset timer 0x0003 issued on the counter==1 edge of quantum 8: no expiry; the next timer request comes 3 cycles later.
- Reset asserted in REQ: int_req=0, sched_running=0 and all vectors 0 after the edge. A subsequent int_ack has no effect.
